// File: rtl/adder_sweep_pkg.sv
// Shared definitions for the ripple-adder self-test sweep: state encoding,
// last vector index and the reference sum used by the checker.
package adder_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [4:0] VEC_LAST = 5'd31;

    function automatic logic [2:0] exp_sum(input logic [1:0] a, input logic [1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {2'b00, ci};
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Per-vector elapsed-clock counter. Saturates so a long step-mode hold
// never wraps back below the auto-mode exit threshold.
module sweep_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/adder_sweep_ctrl.sv
// Self-test sequencer: walks all 32 {A,B,CI} vectors through the adder,
// holds each for display and counts result mismatches.
//
// state  | meaning
// IDLE   | waiting for start after reset
// APPLY  | new vector driven, timer cleared (1 clk)
// SETTLE | waiting SETTLE_CYCLES unpaused clocks for the adder output
// CHECK  | sum_in compared with the expected sum (1 clk)
// HOLD   | vector held for display until timeout or step
// DONE   | sweep finished, last vector held, results valid
module adder_sweep_ctrl
    import adder_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES   = 100_000_000,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       step_mode,
    input  logic       step,
    input  logic [2:0] sum_in,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic       CI,
    output logic [4:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic [5:0] err_count,
    output logic [4:0] first_err_idx
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);

    // The timer is cleared on the APPLY edge, so it lags the clocks elapsed
    // since APPLY entry by the APPLY cycle and the current cycle.
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 2);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          hold_exit;

    assign A         = vec_idx[4:3];
    assign B         = vec_idx[2:1];
    assign CI        = vec_idx[0];
    assign timer_clr = (state == APPLY);
    assign hold_exit = !pause && (step_mode ? step : (timer >= HOLD_LAST));

    sweep_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (~pause),
        .count(timer)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            vec_idx       <= 5'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= 6'd0;
            first_err_idx <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= APPLY;
                        vec_idx       <= 5'd0;
                        err_count     <= 6'd0;
                        first_err_idx <= 5'd0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                    end
                end
                APPLY: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (!pause && (timer >= SETTLE_LAST)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (sum_in != exp_sum(A, B, CI)) begin
                        err_count <= err_count + 6'd1;
                        if (err_count == 6'd0) begin
                            first_err_idx <= vec_idx;
                        end
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (hold_exit) begin
                        if (vec_idx == VEC_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec_idx <= vec_idx + 5'd1;
                            state   <= APPLY;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Self-checking bench for adder_sweep_ctrl with a golden adder on sum_in,
// optional fault injection and per-vector duration tracking.
module tb_adder_sweep_ctrl;

    localparam int HOLD   = 8;
    localparam int SETTLE = 2;
    localparam int PER    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic [2:0] sum_in;
    logic [1:0] a, b;
    logic       ci;
    logic [4:0] vec_idx;
    logic       busy, done;
    logic [5:0] err_count;
    logic [4:0] first_err_idx;

    logic [2:0]  and_mask = 3'b111;
    logic [2:0]  xor_mask = 3'b000;
    logic [31:0] xor_sel  = 32'h0;
    logic [2:0]  golden;

    int compared   = 0;
    int mismatched = 0;
    int dur[32];
    int abc_bad = 0;
    logic busy_q = 1'b0;

    always #(PER/2) clk = ~clk;

    assign golden = {1'b0, a} + {1'b0, b} + {2'b00, ci};
    assign sum_in = (golden & and_mask) ^ (xor_sel[{a, b, ci}] ? xor_mask : 3'b000);

    adder_sweep_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause        (pause),
        .step_mode    (step_mode),
        .step         (step),
        .sum_in       (sum_in),
        .A            (a),
        .B            (b),
        .CI           (ci),
        .vec_idx      (vec_idx),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .first_err_idx(first_err_idx)
    );

    // Clocks spent on each vector during a sweep; restarts when busy rises.
    always @(negedge clk) begin
        if (busy) begin
            if (!busy_q) begin
                for (int i = 0; i < 32; i++) dur[i] = 0;
                abc_bad = 0;
            end
            dur[vec_idx] = dur[vec_idx] + 1;
            if ({a, b, ci} !== vec_idx) abc_bad = abc_bad + 1;
        end
        busy_q = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idx(input logic [4:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy && vec_idx == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Expected sweep result from the adder rules and the active fault setup.
    task automatic model_sweep(output int exp_err, output int exp_first);
        int s, got;
        exp_err = 0;
        exp_first = 0;
        for (int i = 0; i < 32; i++) begin
            s   = ((i >> 3) & 3) + ((i >> 1) & 3) + (i & 1);
            got = (s & int'(and_mask)) ^ (xor_sel[i] ? int'(xor_mask) : 0);
            if (got != s) begin
                if (exp_err == 0) exp_first = i;
                exp_err++;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        tick(2);
        compared++;
        if ({a, b, ci, vec_idx, busy, done, err_count, first_err_idx} !== 23'd0) begin
            mismatched++;
            $display("FAIL reset_hold: outputs=%h want 0", {a, b, ci, vec_idx, busy, done, err_count, first_err_idx});
        end
        rst = 1'b0;
        tick(3);
        compared++;
        if ({a, b, ci, vec_idx, busy, done, err_count, first_err_idx} !== 23'd0) begin
            mismatched++;
            $display("FAIL reset_release: outputs=%h want 0", {a, b, ci, vec_idx, busy, done, err_count, first_err_idx});
        end
        and_mask = 3'b110;
        pulse_start;
        wait_idx(5'd6, 100, ok);
        compared++;
        if (!ok || err_count !== 6'd3) begin
            mismatched++;
            $display("FAIL reset_presweep: reached=%0d err_count=%0d want 1/3", ok, err_count);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({a, b, ci, vec_idx, busy, done, err_count, first_err_idx} !== 23'd0) begin
            mismatched++;
            $display("FAIL reset_async: outputs=%h want 0", {a, b, ci, vec_idx, busy, done, err_count, first_err_idx});
        end
        @(negedge clk);
        rst = 1'b0;
        and_mask = 3'b111;
        tick(5);
        compared++;
        if ({vec_idx, busy, done, err_count} !== 13'd0) begin
            mismatched++;
            $display("FAIL reset_no_resume: idx=%0d busy=%0d done=%0d err=%0d want 0", vec_idx, busy, done, err_count);
        end
    endtask

    task automatic test_full_sweep;
        bit ok;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL sweep_pre_busy: busy=%0d want 0", busy);
        end
        pulse_start;
        compared++;
        if (busy !== 1'b1 || vec_idx !== 5'd0) begin
            mismatched++;
            $display("FAIL sweep_start: busy=%0d idx=%0d want 1/0", busy, vec_idx);
        end
        wait_idx(5'd23, 300, ok);
        compared++;
        if (!ok || a !== 2'd2 || b !== 2'd3 || ci !== 1'b1) begin
            mismatched++;
            $display("FAIL sweep_idx23: A=%0d B=%0d CI=%0d want 2/3/1", a, b, ci);
        end
        wait_done(300, ok);
        compared++;
        if (!ok || err_count !== 6'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL sweep_done: done=%0d err=%0d busy=%0d want 1/0/0", ok, err_count, busy);
        end
        compared++;
        if ({a, b, ci} !== 5'd31) begin
            mismatched++;
            $display("FAIL sweep_last_vec: vec=%0d want 31", {a, b, ci});
        end
        for (int i = 0; i < 32; i++) begin
            compared++;
            if (dur[i] != HOLD) begin
                mismatched++;
                $display("FAIL sweep_dur[%0d]: %0d clks want %0d", i, dur[i], HOLD);
            end
        end
        compared++;
        if (abc_bad != 0) begin
            mismatched++;
            $display("FAIL sweep_abc_map: %0d bad cycles want 0", abc_bad);
        end
    endtask

    task automatic test_fault;
        bit ok;
        and_mask = 3'b110;
        pulse_start;
        wait_done(300, ok);
        compared++;
        if (!ok || err_count !== 6'd16 || first_err_idx !== 5'd1) begin
            mismatched++;
            $display("FAIL fault_s0: done=%0d err=%0d first=%0d want 1/16/1", ok, err_count, first_err_idx);
        end
        and_mask = 3'b111;
    endtask

    task automatic test_random_faults;
        bit ok;
        int exp_err, exp_first;
        for (int n = 0; n < 3; n++) begin
            xor_mask = 3'($urandom_range(1, 7));
            xor_sel  = $urandom;
            model_sweep(exp_err, exp_first);
            pulse_start;
            wait_done(300, ok);
            compared++;
            if (!ok || int'(err_count) != exp_err) begin
                mismatched++;
                $display("FAIL rand_fault_count[%0d]: err=%0d want %0d", n, err_count, exp_err);
            end
            if (exp_err != 0) begin
                compared++;
                if (int'(first_err_idx) != exp_first) begin
                    mismatched++;
                    $display("FAIL rand_fault_first[%0d]: first=%0d want %0d", n, first_err_idx, exp_first);
                end
            end
        end
        xor_sel  = 32'h0;
        xor_mask = 3'b000;
    endtask

    task automatic test_pause;
        bit ok;
        int v, k, len;
        int offs[6] = '{1, 2, 4, 5, 6, 7};
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin
                v = 4; k = 4; len = 5;
            end else begin
                v   = $urandom_range(0, 31);
                k   = offs[$urandom_range(0, 5)];
                len = $urandom_range(1, 6);
            end
            pulse_start;
            wait_idx(5'(v), 300, ok);
            tick(k);
            pause = 1'b1;
            tick(len);
            pause = 1'b0;
            wait_done(300, ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("FAIL pause_done[%0d]: done=%0d want 1", n, ok);
            end
            for (int i = 0; i < 32; i++) begin
                compared++;
                if (dur[i] != ((i == v) ? HOLD + len : HOLD)) begin
                    mismatched++;
                    $display("FAIL pause_dur[%0d][%0d]: %0d clks want %0d", n, i, dur[i], (i == v) ? HOLD + len : HOLD);
                end
            end
        end
    endtask

    task automatic test_step_mode;
        bit ok;
        step_mode = 1'b1;
        pulse_start;
        tick(100);
        compared++;
        if (vec_idx !== 5'd0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL step_wait: idx=%0d busy=%0d want 0/1", vec_idx, busy);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        compared++;
        if (vec_idx !== 5'd1) begin
            mismatched++;
            $display("FAIL step_hold: idx=%0d want 1", vec_idx);
        end
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(20);
        compared++;
        if (vec_idx !== 5'd1) begin
            mismatched++;
            $display("FAIL step_in_settle: idx=%0d want 1", vec_idx);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        compared++;
        if (vec_idx !== 5'd2) begin
            mismatched++;
            $display("FAIL step_second: idx=%0d want 2", vec_idx);
        end
        tick(20);
        step_mode = 1'b0;
        tick(1);
        compared++;
        if (vec_idx !== 5'd3) begin
            mismatched++;
            $display("FAIL step_to_auto: idx=%0d want 3", vec_idx);
        end
        wait_done(300, ok);
        compared++;
        if (!ok || err_count !== 6'd0) begin
            mismatched++;
            $display("FAIL step_done: done=%0d err=%0d want 1/0", ok, err_count);
        end
    endtask

    task automatic test_reset_mid_sweep;
        bit ok;
        and_mask = 3'b110;
        pulse_start;
        wait_idx(5'd10, 300, ok);
        compared++;
        if (!ok || err_count !== 6'd5 || first_err_idx !== 5'd1) begin
            mismatched++;
            $display("FAIL mid_pre: reached=%0d err=%0d first=%0d want 1/5/1", ok, err_count, first_err_idx);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (vec_idx !== 5'd0 || busy !== 1'b0 || err_count !== 6'd0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: idx=%0d busy=%0d err=%0d done=%0d want 0", vec_idx, busy, err_count, done);
        end
        @(negedge clk);
        rst = 1'b0;
        and_mask = 3'b111;
        tick(2);
        pulse_start;
        compared++;
        if (vec_idx !== 5'd0 || busy !== 1'b1 || err_count !== 6'd0) begin
            mismatched++;
            $display("FAIL mid_restart: idx=%0d busy=%0d err=%0d want 0/1/0", vec_idx, busy, err_count);
        end
        tick(10);
        start = 1'b1;
        tick(60);
        start = 1'b0;
        wait_done(300, ok);
        compared++;
        if (!ok || err_count !== 6'd0) begin
            mismatched++;
            $display("FAIL mid_done: done=%0d err=%0d want 1/0", ok, err_count);
        end
        for (int i = 0; i < 32; i++) begin
            compared++;
            if (dur[i] != HOLD) begin
                mismatched++;
                $display("FAIL busy_start_dur[%0d]: %0d clks want %0d", i, dur[i], HOLD);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_full_sweep;
        test_fault;
        test_random_faults;
        test_pause;
        test_step_mode;
        test_reset_mid_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
